// File: rtl/timer_pwm_cfg_ctrl.sv
// timer_pwm_cfg_ctrl: bus-programmed shadow registers committed to a PWM timer at period boundaries or immediately.
module timer_pwm_cfg_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter logic [DATA_W-1:0] TOP_RST = 32'h0000_00FF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    input  logic              timer_interrupt,
    output logic [1:0]        TMR_SRC,
    output logic [1:0]        TMR_MODE,
    output logic [DATA_W-1:0] TIMER_TOP,
    output logic [DATA_W-1:0] PWM_CNTA,
    output logic [DATA_W-1:0] PWM_CNTB,
    output logic              timer_reset,
    output logic              irq
);
    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_TOP  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_CNTA = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_CNTB = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_CMD  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_PCNT = ADDR_W'(6);

    typedef enum logic [1:0] {IDLE, PENDING, APPLY, RESTART} state_t;
    state_t state_q, state_d;

    logic [1:0]        sh_src_q, sh_mode_q, act_src_q, act_mode_q;
    logic              sh_en_q, sh_ie_q, act_en_q;
    logic [DATA_W-1:0] sh_top_q, sh_cnta_q, sh_cntb_q;
    logic [DATA_W-1:0] act_top_q, act_cnta_q, act_cntb_q;
    logic [DATA_W-1:0] per_cnt_q, rdata_q, rd_val;
    logic              irq_flag_q, cfg_err_q, ack_q, trst_q, ti_q, bnd_q;
    logic              rcnt_q, rcnt_d;
    logic              rd, commit, restart, bnd, evt, changed, do_apply, set_err;
    logic              wr_stat, pending;

    assign rd      = rd_en & ~wr_en;
    assign commit  = wr_en && addr == A_CMD && wdata[0];
    assign wr_stat = wr_en && addr == A_STAT;
    assign restart = state_q == RESTART;
    assign pending = state_q != IDLE;
    // A boundary latched on the edge into RESTART belongs to the old configuration
    assign bnd     = bnd_q & ~restart;
    assign evt     = bnd & act_en_q;
    assign changed = sh_src_q != act_src_q || sh_mode_q != act_mode_q || sh_en_q != act_en_q;

    always_comb begin
        state_d  = state_q;
        do_apply = 1'b0;
        set_err  = 1'b0;
        rcnt_d   = restart & ~rcnt_q;
        case (state_q)
            IDLE:    if (commit) state_d = (wdata[1] || !act_en_q) ? APPLY : PENDING;
            PENDING: if ((commit && wdata[1]) || bnd) state_d = APPLY;
            APPLY: begin
                set_err  = sh_top_q == '0;
                do_apply = !set_err;
                state_d  = (do_apply && changed) ? RESTART : IDLE;
            end
            RESTART: if (rcnt_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            A_CTRL: rd_val = {{(DATA_W-6){1'b0}}, sh_ie_q, sh_en_q, sh_mode_q, sh_src_q};
            A_TOP:  rd_val = sh_top_q;
            A_CNTA: rd_val = sh_cnta_q;
            A_CNTB: rd_val = sh_cntb_q;
            A_STAT: rd_val = {{(DATA_W-3){1'b0}}, cfg_err_q, irq_flag_q, pending};
            A_PCNT: rd_val = per_cnt_q;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rcnt_q     <= 1'b0;
            sh_src_q   <= '0;
            sh_mode_q  <= '0;
            sh_en_q    <= 1'b0;
            sh_ie_q    <= 1'b0;
            sh_top_q   <= TOP_RST;
            sh_cnta_q  <= '0;
            sh_cntb_q  <= '0;
            act_src_q  <= '0;
            act_mode_q <= '0;
            act_en_q   <= 1'b0;
            act_top_q  <= TOP_RST;
            act_cnta_q <= '0;
            act_cntb_q <= '0;
            per_cnt_q  <= '0;
            irq_flag_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            trst_q     <= 1'b1;
            ti_q       <= 1'b0;
            bnd_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            trst_q  <= 1'b0;
            ack_q   <= wr_en | rd_en;
            rdata_q <= rd ? rd_val : '0;
            if (wr_en && addr == A_CTRL) begin
                sh_src_q  <= wdata[1:0];
                sh_mode_q <= wdata[3:2];
                sh_en_q   <= wdata[4];
                sh_ie_q   <= wdata[5];
            end
            if (wr_en && addr == A_TOP) sh_top_q <= wdata;
            if (wr_en && addr == A_CNTA) sh_cnta_q <= wdata;
            if (wr_en && addr == A_CNTB) sh_cntb_q <= wdata;
            if (do_apply) begin
                act_src_q  <= sh_src_q;
                act_mode_q <= sh_mode_q;
                act_en_q   <= sh_en_q;
                act_top_q  <= sh_top_q;
                act_cnta_q <= sh_cnta_q > sh_top_q ? sh_top_q : sh_cnta_q;
                act_cntb_q <= sh_cntb_q > sh_top_q ? sh_top_q : sh_cntb_q;
            end
            irq_flag_q <= evt | (irq_flag_q & ~(wr_stat & wdata[1]));
            cfg_err_q  <= set_err | (cfg_err_q & ~(wr_stat & wdata[2]));
            per_cnt_q  <= (restart || (wr_en && addr == A_PCNT)) ? '0 :
                          evt ? per_cnt_q + DATA_W'(1) : per_cnt_q;
            ti_q  <= restart ? 1'b0 : timer_interrupt;
            bnd_q <= restart ? 1'b0 : timer_interrupt & ~ti_q;
        end
    end

    assign rdata       = rdata_q;
    assign ack         = ack_q;
    assign TMR_SRC     = act_en_q ? act_src_q : 2'b00;
    assign TMR_MODE    = act_mode_q;
    assign TIMER_TOP   = act_top_q;
    assign PWM_CNTA    = act_cnta_q;
    assign PWM_CNTB    = act_cntb_q;
    assign timer_reset = trst_q | restart;
    assign irq         = irq_flag_q & sh_ie_q;
endmodule

// File: tb/tb_timer_pwm_cfg_ctrl.sv
// tb_timer_pwm_cfg_ctrl: directed plus randomized bus/interrupt stimulus checked every cycle against a behavioural model.
module tb_timer_pwm_cfg_ctrl;
    logic        clk = 1'b0, reset = 1'b1, wr_en = 1'b0, rd_en = 1'b0, timer_interrupt = 1'b0;
    logic [2:0]  addr = '0;
    logic [31:0] wdata = '0, rdata, TIMER_TOP, PWM_CNTA, PWM_CNTB;
    logic [1:0]  TMR_SRC, TMR_MODE;
    logic        ack, timer_reset, irq;

    timer_pwm_cfg_ctrl dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .timer_interrupt(timer_interrupt), .TMR_SRC(TMR_SRC),
        .TMR_MODE(TMR_MODE), .TIMER_TOP(TIMER_TOP), .PWM_CNTA(PWM_CNTA), .PWM_CNTB(PWM_CNTB),
        .timer_reset(timer_reset), .irq(irq)
    );

    always #5 clk = ~clk;

    // Model: shadow (m_s*) and active (m_a*) config, phase 0 idle, 1 waiting, 2 apply, 3 restart
    logic [1:0]  m_ssrc, m_smode, m_asrc, m_amode;
    logic        m_sen, m_sie, m_aen, m_flag, m_err, m_ack, m_trst, m_tip, m_bnd;
    logic [31:0] m_stop, m_sa, m_sb, m_atop, m_aa, m_ab, m_cnt, m_rdata;
    int          m_ph, m_rl;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, we, re, input logic [2:0] a, input logic [31:0] d, input logic ti);
        logic [31:0] rv;
        logic        commit, bnd, ev, seterr;
        int          nph, nrl;
        if (r) begin
            {m_ssrc, m_smode, m_sen, m_sie} = '0;
            {m_asrc, m_amode, m_aen} = '0;
            m_stop = 32'hFF; m_atop = 32'hFF;
            {m_sa, m_sb, m_aa, m_ab, m_cnt, m_rdata} = '0;
            {m_flag, m_err, m_ack, m_tip, m_bnd} = '0;
            m_trst = 1'b1; m_ph = 0; m_rl = 0;
            return;
        end
        case (a)
            3'd0: rv = {26'd0, m_sie, m_sen, m_smode, m_ssrc};
            3'd1: rv = m_stop;
            3'd2: rv = m_sa;
            3'd3: rv = m_sb;
            3'd5: rv = {29'd0, m_err, m_flag, (m_ph != 0)};
            3'd6: rv = m_cnt;
            default: rv = '0;
        endcase
        commit = we && a == 3'd4 && d[0];
        bnd = m_bnd && m_ph != 3;
        ev = bnd && m_aen;
        seterr = 1'b0;
        nph = m_ph; nrl = m_rl;
        if (m_ph == 0 && commit) nph = (d[1] || !m_aen) ? 2 : 1;
        else if (m_ph == 1 && ((commit && d[1]) || bnd)) nph = 2;
        else if (m_ph == 2) begin
            if (m_stop == 0) begin
                seterr = 1'b1; nph = 0;
            end else begin
                nph = (m_ssrc != m_asrc || m_smode != m_amode || m_sen != m_aen) ? 3 : 0;
                nrl = 2;
                m_asrc = m_ssrc; m_amode = m_smode; m_aen = m_sen; m_atop = m_stop;
                m_aa = (m_sa > m_stop) ? m_stop : m_sa;
                m_ab = (m_sb > m_stop) ? m_stop : m_sb;
            end
        end else if (m_ph == 3) begin
            nrl = m_rl - 1;
            nph = (nrl == 0) ? 0 : 3;
        end
        if (we && a == 3'd5) begin
            if (d[1]) m_flag = 1'b0;
            if (d[2]) m_err = 1'b0;
        end
        if (ev) m_flag = 1'b1;
        if (seterr) m_err = 1'b1;
        if (m_ph == 3 || (we && a == 3'd6)) m_cnt = '0;
        else if (ev) m_cnt = m_cnt + 1;
        if (we) case (a)
            3'd0: begin m_ssrc = d[1:0]; m_smode = d[3:2]; m_sen = d[4]; m_sie = d[5]; end
            3'd1: m_stop = d;
            3'd2: m_sa = d;
            3'd3: m_sb = d;
            default: ;
        endcase
        if (m_ph == 3) begin
            m_tip = 1'b0; m_bnd = 1'b0;
        end else begin
            m_bnd = ti && !m_tip; m_tip = ti;
        end
        m_ph = nph; m_rl = nrl;
        m_ack = we || re;
        m_rdata = (re && !we) ? rv : '0;
        m_trst = 1'b0;
    endtask

    // One clock: drive at the falling edge, advance the model, then compare after the rising edge
    task automatic cyc(input logic r, we, re, input logic [2:0] a, input logic [31:0] d, input logic ti);
        reset = r; wr_en = we; rd_en = re; addr = a; wdata = d; timer_interrupt = ti;
        model_step(r, we, re, a, d, ti);
        @(negedge clk);
        chk("rdata", rdata, m_rdata);
        chk("ack", 32'(ack), 32'(m_ack));
        chk("TMR_SRC", 32'(TMR_SRC), 32'(m_aen ? m_asrc : 2'b00));
        chk("TMR_MODE", 32'(TMR_MODE), 32'(m_amode));
        chk("TIMER_TOP", TIMER_TOP, m_atop);
        chk("PWM_CNTA", PWM_CNTA, m_aa);
        chk("PWM_CNTB", PWM_CNTB, m_ab);
        chk("timer_reset", 32'(timer_reset), 32'(m_trst || m_ph == 3));
        chk("irq", 32'(irq), 32'(m_flag & m_sie));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b0, a, d, 1'b0);
    endtask

    task automatic rd_exp(input string nm, input logic [2:0] a, input logic [31:0] exp);
        cyc(1'b0, 1'b0, 1'b1, a, 32'd0, 1'b0);
        chk(nm, rdata, exp);
        chk({nm, "_ack"}, 32'(ack), 32'd1);
    endtask

    task automatic pulse();
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] d;
        logic [2:0]  a;
        logic        r, we, re, ti;
        @(negedge clk);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        chk("rst_timer_reset", 32'(timer_reset), 32'd1);
        chk("rst_top", TIMER_TOP, 32'hFF);
        idle(1);
        chk("trst_fall", 32'(timer_reset), 32'd0);
        rd_exp("rd_ctrl", 3'd0, 32'd0);
        rd_exp("rd_top", 3'd1, 32'hFF);
        rd_exp("rd_cnta", 3'd2, 32'd0);
        rd_exp("rd_cntb", 3'd3, 32'd0);
        rd_exp("rd_cmd", 3'd4, 32'd0);
        rd_exp("rd_status", 3'd5, 32'd0);
        rd_exp("rd_pcnt", 3'd6, 32'd0);
        rd_exp("rd_7", 3'd7, 32'd0);
        // Enable with source 01 from a disabled timer: applies at once, then restarts
        wr(3'd2, 32'h50);
        wr(3'd0, 32'h11);
        wr(3'd4, 32'h1);
        idle(1);
        chk("restart_pulse", 32'(timer_reset), 32'd1);
        idle(3);
        chk("en_src", 32'(TMR_SRC), 32'd1);
        chk("en_mode", 32'(TMR_MODE), 32'd0);
        chk("en_cnta", PWM_CNTA, 32'h50);
        // Deferred commit waits for the period boundary
        wr(3'd2, 32'h80);
        wr(3'd4, 32'h1);
        idle(2);
        rd_exp("pending", 3'd5, 32'd1);
        chk("hold_cnta", PWM_CNTA, 32'h50);
        pulse();
        chk("hold_cnta2", PWM_CNTA, 32'h50);
        idle(1);
        chk("upd_cnta", PWM_CNTA, 32'h80);
        chk("no_restart", 32'(timer_reset), 32'd0);
        // Immediate apply with clamping, then a rejected zero TOP
        wr(3'd1, 32'h40);
        wr(3'd2, 32'h50);
        wr(3'd3, 32'hA0);
        wr(3'd4, 32'h3);
        idle(2);
        chk("clamp_top", TIMER_TOP, 32'h40);
        chk("clamp_a", PWM_CNTA, 32'h40);
        chk("clamp_b", PWM_CNTB, 32'h40);
        wr(3'd1, 32'h0);
        wr(3'd4, 32'h3);
        idle(2);
        rd_exp("cfg_err", 3'd5, 32'h6);
        chk("err_top", TIMER_TOP, 32'h40);
        // Period counting and interrupt; W1C loses against a same-cycle boundary
        wr(3'd0, 32'h31);
        wr(3'd5, 32'h6);
        wr(3'd6, 32'h0);
        for (int i = 0; i < 5; i++) pulse();
        idle(1);
        rd_exp("pcnt5", 3'd6, 32'd5);
        chk("irq5", 32'(irq), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        wr(3'd5, 32'h2);
        chk("irq_set_wins", 32'(irq), 32'd1);
        rd_exp("pcnt6", 3'd6, 32'd6);
        // Reset while a mode change is pending
        wr(3'd0, 32'h39);
        wr(3'd4, 32'h1);
        idle(1);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        chk("mid_src", 32'(TMR_SRC), 32'd0);
        chk("mid_top", TIMER_TOP, 32'hFF);
        chk("mid_cnta", PWM_CNTA, 32'd0);
        chk("mid_trst", 32'(timer_reset), 32'd1);
        rd_exp("mid_status", 3'd5, 32'd0);
        // Randomized traffic
        ti = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            r = $urandom_range(0, 399) == 0;
            we = $urandom_range(0, 9) < 3;
            re = $urandom_range(0, 9) < 3;
            a = 3'($urandom_range(0, 7));
            case (a)
                3'd0: d = 32'($urandom_range(0, 63));
                3'd1: d = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 255));
                3'd2, 3'd3: d = 32'($urandom_range(0, 300));
                3'd4: d = 32'($urandom_range(0, 3));
                3'd5: d = 32'($urandom_range(0, 7));
                default: d = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ti = ~ti;
            cyc(r, we, re, a, d, ti);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/timer_pwm_cfg_ctrl.md
Name: timer_pwm_cfg_ctrl

Overview:
Bus-facing configuration controller for Timer_PWM_Generator. Software writes shadow registers over a simple single-cycle request/ack bus. A commit state machine transfers the shadow values to the timer's configuration inputs, either at the next period boundary (rising edge of timer_interrupt) or immediately. A change of mode or source also restarts the timer. The block also counts periods and raises a maskable interrupt.

Parameters:
DATA_W, 32, width of bus data and of TIMER_TOP/PWM_CNTA/PWM_CNTB
ADDR_W, 3, bus address width (8 word registers)
TOP_RST, 32'h0000_00FF, reset value of the active and shadow TIMER_TOP

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  bus write request (one-cycle strobe)
rd_en  in  1  bus read request (one-cycle strobe); wr_en has priority if both are high
addr  in  ADDR_W  register address
wdata  in  DATA_W  write data
rdata  out  DATA_W  read data, valid while ack=1
ack  out  1  one-cycle acknowledge
timer_interrupt  in  1  period-boundary indication from the timer
TMR_SRC  out  2  active timer source to the timer
TMR_MODE  out  2  active mode to the timer (00 normal, 01 fast PWM, 10 phase-correct)
TIMER_TOP  out  DATA_W  active top value
PWM_CNTA  out  DATA_W  active compare A
PWM_CNTB  out  DATA_W  active compare B
timer_reset  out  1  reset drive to the timer
irq  out  1  interrupt to the CPU

Behaviour:
- Register map (word addresses):
  - 0 CTRL: [1:0] src, [3:2] mode, [4] enable, [5] irq_en.
  - 1 TOP, 2 CNTA, 3 CNTB: shadow registers.
  - 4 CMD (write-only): bit0 = commit, bit1 = immediate.
  - 5 STATUS: [0] pending (RO), [1] irq_flag (write 1 to clear), [2] cfg_err (write 1 to clear).
  - 6 PERIOD_CNT: RO count; any write clears it.
  - 7: reads 0, writes ignored.
- Reads return shadow values for addresses 0-3, 0 for address 4, and live status/count for 5-6.
- Bus handshake: ack goes high exactly 1 cycle after wr_en or rd_en and lasts 1 cycle. rdata is registered and held at 0 when ack=0. Requests issued on back-to-back cycles are all acked.
- Reset values:
  - Shadow and active regs: src=00, mode=00, enable=0, irq_en=0, TOP=TOP_RST, CNTA=0, CNTB=0.
  - Outputs: TMR_SRC=00, TMR_MODE=00, TIMER_TOP=TOP_RST, PWM_CNTA/B=0, rdata=0, ack=0, irq=0.
  - timer_reset=1 during reset; it falls on the first clock after reset deasserts.
  - STATUS=0, PERIOD_CNT=0, FSM=IDLE.
- Output drive: TMR_SRC = active_enable ? active_src : 2'b00. The other outputs equal the active registers directly.
- Boundary event: rising edge of timer_interrupt, registered detect, so 1 cycle of latency.
  - When active_enable=1, each boundary increments PERIOD_CNT (wrapping at 2^32) and sets irq_flag.
  - irq = irq_flag & shadow irq_en.
- FSM states: IDLE, PENDING, APPLY, RESTART.
  - IDLE: a CMD write with bit0=1 goes to PENDING and sets pending. If bit1=1, or active_enable=0, it goes straight to APPLY instead.
  - PENDING: waits for a boundary event, then goes to APPLY. A boundary detected in the same cycle as the commit write does not count. Shadow writes while PENDING are allowed; the values present on entry to APPLY are the ones used. A second commit in PENDING is acked with no effect, except that bit1=1 escalates to APPLY on the next cycle.
  - APPLY (1 cycle), validation:
    - Shadow TOP=0: set cfg_err, leave active unchanged, clear pending, go to IDLE.
    - Otherwise copy shadow to active. CNTA/CNTB are clamped to TOP if greater.
    - If src, mode or enable differs from active, go to RESTART. Otherwise clear pending and go to IDLE.
  - RESTART: timer_reset=1 for 2 cycles, PERIOD_CNT cleared, boundary detector cleared, then pending cleared and go to IDLE.
- Simultaneous events:
  - A STATUS W1C and an irq_flag set in the same cycle: the set wins.
  - A PERIOD_CNT write and a boundary in the same cycle: the count becomes 0.
- Reset asserted mid-operation (any state): everything returns to reset values on the next edge. The pending commit is lost.

Test Plan:
1. Reset, then read all addresses → TOP=0xFF, STATUS=0, PERIOD_CNT=0. Each read is acked 1 cycle after rd_en, and timer_reset is low by the second cycle after release.
2. Write CTRL=0x11 (src 01, enable), CMD=0x1 → immediate apply (enable=0 before), RESTART 2 cycles, then TMR_SRC=01 and TMR_MODE=00.
3. Running: write CNTA=0x80, CMD=0x1 → pending=1 and PWM_CNTA stays 0x50 until a timer_interrupt rising edge. It updates 3 cycles after that edge (detect, APPLY) with no timer_reset pulse.
4. Write TOP=0x40, CNTA=0x50, CNTB=0xA0, CMD=0x3 → immediate apply with TIMER_TOP=0x40 and PWM_CNTA=PWM_CNTB=0x40 (clamped). Then TOP=0, CMD=0x3 → cfg_err=1 and outputs unchanged.
5. Set irq_en, issue 5 interrupt pulses → PERIOD_CNT=5, irq=1. Write STATUS=0x2 coinciding with a 6th pulse → irq stays 1 and PERIOD_CNT=6.
6. Change mode to 10 with CMD=0x1 pending, assert reset before the boundary → all outputs return to reset values and pending=0.
